// File: rtl/bidir_bus_pkg.sv
// bidir_bus_pkg: shared state encoding and counter sizing for bidir_bus_ctrl
package bidir_bus_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, TURN, RWAIT} state_t;
  function automatic int cnt_width(input int h, input int t, input int r);
    int m;
    m = h > t ? h : t;
    m = m > r ? m : r;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/bidir_bus_ctrl.sv
// bidir_bus_ctrl: tri-state bus master with timed write drive, turnaround and read sampling
module bidir_bus_ctrl
  import bidir_bus_pkg::*;
#(
  parameter int N           = 16,
  parameter int HOLD_CYCLES = 1,
  parameter int TURN_CYCLES = 1,
  parameter int READ_LAT    = 2
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         ReqValid,
  output logic         ReqReady,
  input  logic         ReqWrite,
  input  logic [N-1:0] ReqData,
  output logic         RspValid,
  output logic         RspWrite,
  output logic [N-1:0] RspData,
  output logic         BusOE,
  inout  wire  [N-1:0] Data
);
  localparam int CW = cnt_width(HOLD_CYCLES, TURN_CYCLES, READ_LAT);
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           oe_q, oe_d, rv_q, rv_d, rw_q, rw_d;
  logic [N-1:0]   out_q, out_d, rd_q, rd_d;
  assign ReqReady = (state_q == IDLE) && Reset_n;
  assign BusOE    = oe_q;
  assign RspValid = rv_q;
  assign RspWrite = rw_q;
  assign RspData  = rd_q;
  assign Data     = oe_q ? out_q : {N{1'bz}};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CW'(1);
    oe_d    = oe_q;
    out_d   = out_q;
    rv_d    = 1'b0;
    rw_d    = rw_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (ReqValid) begin
          state_d = ReqWrite ? DRIVE : RWAIT;
          cnt_d   = ReqWrite ? CW'(HOLD_CYCLES - 1) : CW'(READ_LAT - 1);
          oe_d    = ReqWrite;
          out_d   = ReqWrite ? ReqData : out_q;
        end
      end
      DRIVE: if (cnt_q == '0) begin
        state_d = TURN;
        cnt_d   = CW'(TURN_CYCLES - 1);
        oe_d    = 1'b0;
      end
      TURN: if (cnt_q == '0) begin
        state_d = IDLE;
        cnt_d   = '0;
        rv_d    = 1'b1;
        rw_d    = 1'b1;
        rd_d    = '0;
      end
      RWAIT: if (cnt_q == '0) begin
        state_d = IDLE;
        cnt_d   = '0;
        rv_d    = 1'b1;
        rw_d    = 1'b0;
        rd_d    = Data;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      oe_q    <= 1'b0;
      out_q   <= '0;
      rv_q    <= 1'b0;
      rw_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      oe_q    <= oe_d;
      out_q   <= out_d;
      rv_q    <= rv_d;
      rw_q    <= rw_d;
      rd_q    <= rd_d;
    end
  end
endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// tb_bidir_bus_ctrl: directed vector table plus reset and long-hold sequences
module tb_bidir_bus_ctrl;
  typedef struct {
    logic        valid;
    logic        write;
    logic [15:0] req_data;
    logic        drv_en;
    logic [15:0] drv;
    logic        e_ready;
    logic        e_oe;
    logic [15:0] e_bus;
    logic        e_rv;
    logic        e_rw;
    logic [15:0] e_rd;
  } vec_t;
  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        req_valid, req_write, req_ready, rsp_valid, rsp_write, bus_oe;
  logic [15:0] req_data, rsp_data;
  logic        tb_en;
  logic [15:0] tb_drv;
  wire  [15:0] data;
  logic        b_valid, b_write, b_ready, b_rv, b_rw, b_oe;
  logic [15:0] b_data, b_rd;
  wire  [15:0] b_bus;
  int          checks = 0;
  int          failures = 0;
  vec_t        v [15];
  always #5 Clk = ~Clk;
  assign data = tb_en ? tb_drv : 16'hzzzz;
  bidir_bus_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .ReqValid(req_valid), .ReqReady(req_ready),
    .ReqWrite(req_write), .ReqData(req_data), .RspValid(rsp_valid),
    .RspWrite(rsp_write), .RspData(rsp_data), .BusOE(bus_oe), .Data(data)
  );
  bidir_bus_ctrl #(.N(16), .HOLD_CYCLES(3), .TURN_CYCLES(2), .READ_LAT(2)) dut3 (
    .Clk(Clk), .Reset_n(Reset_n), .ReqValid(b_valid), .ReqReady(b_ready),
    .ReqWrite(b_write), .ReqData(b_data), .RspValid(b_rv),
    .RspWrite(b_rw), .RspData(b_rd), .BusOE(b_oe), .Data(b_bus)
  );
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n_oe, n_z;
    logic done, order_ok;
    v[0]  = '{1'b1, 1'b1, 16'hBEEF, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
    v[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0000};
    v[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
    v[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000};
    v[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000};
    v[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000};
    v[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000};
    v[7]  = '{1'b1, 1'b1, 16'hA5A5, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234};
    v[8]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hA5A5, 1'b0, 1'b0, 16'h1234};
    v[9]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234};
    v[10] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000};
    v[11] = '{1'b1, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000};
    v[12] = '{1'b1, 1'b1, 16'hFFFF, 1'b1, 16'h5A5A, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000};
    v[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h5A5A};
    v[14] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h5A5A};
    Reset_n = 1'b0;
    {req_valid, req_write, req_data, tb_en, tb_drv} = '0;
    {b_valid, b_write, b_data} = '0;
    next_cycle();
    next_cycle();
    @(negedge Clk);
    chk("rst_ready", 16'(req_ready), 16'h0);
    chk("rst_oe", 16'(bus_oe), 16'h0);
    chk("rst_rv", 16'(rsp_valid), 16'h0);
    chk("rst_rw", 16'(rsp_write), 16'h0);
    chk("rst_rd", rsp_data, 16'h0);
    chk("rst_b_ready", 16'(b_ready), 16'h0);
    Reset_n = 1'b1;
    next_cycle();
    for (int i = 0; i < 15; i++) begin
      req_valid = v[i].valid;
      req_write = v[i].write;
      req_data  = v[i].req_data;
      tb_en     = v[i].drv_en;
      tb_drv    = v[i].drv;
      @(negedge Clk);
      chk($sformatf("v%0d_ready", i), 16'(req_ready), 16'(v[i].e_ready));
      chk($sformatf("v%0d_oe", i), 16'(bus_oe), 16'(v[i].e_oe));
      if (v[i].e_oe) chk($sformatf("v%0d_bus", i), data, v[i].e_bus);
      chk($sformatf("v%0d_rv", i), 16'(rsp_valid), 16'(v[i].e_rv));
      chk($sformatf("v%0d_rw", i), 16'(rsp_write), 16'(v[i].e_rw));
      chk($sformatf("v%0d_rd", i), rsp_data, v[i].e_rd);
      next_cycle();
    end
    req_valid = 1'b1;
    req_write = 1'b1;
    req_data  = 16'hC3C3;
    @(negedge Clk);
    chk("rstw_accept_ready", 16'(req_ready), 16'h1);
    next_cycle();
    req_valid = 1'b0;
    Reset_n = 1'b0;
    @(negedge Clk);
    chk("rstw_oe", 16'(bus_oe), 16'h1);
    chk("rstw_bus", data, 16'hC3C3);
    next_cycle();
    @(negedge Clk);
    chk("rstw_oe_after", 16'(bus_oe), 16'h0);
    chk("rstw_ready_low", 16'(req_ready), 16'h0);
    chk("rstw_rv_low", 16'(rsp_valid), 16'h0);
    Reset_n = 1'b1;
    next_cycle();
    @(negedge Clk);
    chk("rstw_ready_rel", 16'(req_ready), 16'h1);
    chk("rstw_rv_rel", 16'(rsp_valid), 16'h0);
    chk("rstw_oe_rel", 16'(bus_oe), 16'h0);
    chk("rstw_rd_rel", rsp_data, 16'h0);
    next_cycle();
    @(negedge Clk);
    chk("rstw_rv_rel2", 16'(rsp_valid), 16'h0);
    next_cycle();
    b_valid = 1'b1;
    b_write = 1'b1;
    b_data  = 16'h0F0F;
    @(negedge Clk);
    chk("h3_ready", 16'(b_ready), 16'h1);
    next_cycle();
    b_valid = 1'b0;
    n_oe = 0;
    n_z = 0;
    done = 1'b0;
    order_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (b_ready) begin
        done = 1'b1;
        break;
      end
      if (b_oe) begin
        if (n_z != 0) order_ok = 1'b0;
        n_oe++;
        chk($sformatf("h3_bus%0d", i), b_bus, 16'h0F0F);
      end else n_z++;
      next_cycle();
    end
    chk("h3_done", 16'(done), 16'h1);
    chk("h3_order", 16'(order_ok), 16'h1);
    chk("h3_oe_cycles", 16'(n_oe), 16'd3);
    chk("h3_z_cycles", 16'(n_z), 16'd2);
    chk("h3_rv", 16'(b_rv), 16'h1);
    chk("h3_rw", 16'(b_rw), 16'h1);
    chk("h3_rd", b_rd, 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bidir_bus_ctrl.md
BIDIR_BUS_CTRL -- requirements
Module: bidir_bus_ctrl

Interface
REQ-001 SHALL have parameter N, default 16, giving the bus and data width in bits (N >= 1).
REQ-002 SHALL have parameter HOLD_CYCLES, default 1, giving the number of cycles the bus is driven per write (>= 1).
REQ-003 SHALL have parameter TURN_CYCLES, default 1, giving the number of released dead cycles after each write (>= 1).
REQ-004 SHALL have parameter READ_LAT, default 2, giving the number of wait cycles from read accept to bus sample (>= 1).
REQ-005 SHALL have port Clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port Reset_n, input, 1 bit, a synchronous active-low reset.
REQ-007 SHALL have port ReqValid, input, 1 bit, a request-present flag.
REQ-008 SHALL have port ReqReady, output, 1 bit, the controller-accepts-request flag.
REQ-009 SHALL have port ReqWrite, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port ReqData, input, N bits, the write data.
REQ-011 SHALL have port RspValid, output, 1 bit, a one-cycle completion pulse.
REQ-012 SHALL have port RspWrite, output, 1 bit, the completed operation type.
REQ-013 SHALL have port RspData, output, N bits, the read data; 0 for writes.
REQ-014 SHALL have port BusOE, output, 1 bit, high exactly while the block drives Data.
REQ-015 SHALL have port Data, inout, N bits, the shared tri-state bus.

Function
REQ-016 SHALL implement states IDLE, DRIVE, TURN and RWAIT; ReqReady = 1 only in IDLE.
REQ-017 SHALL treat a request as accepted at an edge where ReqValid && ReqReady; ReqWrite and ReqData are captured at that edge.
REQ-018 SHALL go from IDLE to DRIVE on an accepted write and load the output register with ReqData.
REQ-019 SHALL go from IDLE to RWAIT on an accepted read.
REQ-020 SHALL stay in DRIVE for exactly HOLD_CYCLES cycles, then stay in TURN for exactly TURN_CYCLES cycles, then return to IDLE.
REQ-021 SHALL drive Data = output register when BusOE = 1 and high-Z otherwise; BusOE is registered, with no combinational path from ReqValid.
REQ-022 SHALL keep BusOE = 0 in TURN, RWAIT and IDLE, so the bus is never driven during a read.
REQ-023 SHALL stay in RWAIT for exactly READ_LAT cycles; at the edge ending the last RWAIT cycle it captures Data into RspData and returns to IDLE.
REQ-024 SHALL pulse RspValid for one cycle in the first IDLE cycle after an operation completes: RspWrite = 1 and RspData = 0 for a write; RspWrite = 0 and RspData = captured value for a read.
REQ-025 SHALL allow a new request to be accepted in the same IDLE cycle that carries RspValid (back-to-back operation).
REQ-026 SHALL hold RspData stable until the next RspValid pulse.
REQ-027 SHALL use one down-counter sized $clog2(max(HOLD_CYCLES, TURN_CYCLES, READ_LAT) + 1) bits, reloaded on each state entry.
REQ-028 SHALL give a minimum write-to-write spacing of HOLD_CYCLES + TURN_CYCLES + 1 cycles and a minimum read-to-read spacing of READ_LAT + 1 cycles.
REQ-029 SHALL ignore ReqValid outside IDLE; it has no effect on state.

Reset
REQ-030 SHALL, when Reset_n = 0 at an edge, set state to IDLE, BusOE = 0, RspValid = 0, RspWrite = 0, RspData = 0, the output register to 0 and the counter to 0.
REQ-031 SHALL, on reset mid-DRIVE, release Data to high-Z from the cycle after the reset edge and produce no RspValid for the aborted operation.
REQ-032 SHALL hold ReqReady = 0 while Reset_n = 0 and ReqReady = 1 in the first cycle after release.

Structure
REQ-033 SHALL place the state enum typedef in shared package bidir_bus_pkg.
REQ-034 SHALL implement the whole block in a single module with no sub-module instances.

Verification (N = 16, HOLD = 1, TURN = 1, READ_LAT = 2)
REQ-035 SHALL check: write 0xBEEF accepted at edge 0 -> Data = 0xBEEF and BusOE = 1 in cycle 1; Data = Z in cycle 2; cycle 3 has RspValid = 1, RspWrite = 1, ReqReady = 1.
REQ-036 SHALL check: read accepted at edge 0 with the bench driving 0x1234 in cycle 2 -> BusOE = 0 throughout; cycle 3 has RspValid = 1 and RspData = 0x1234.
REQ-037 SHALL check: write then read back-to-back with ReqValid held -> read accepted in the write's RspValid cycle; at most one driver on Data in every cycle.
REQ-038 SHALL check: Reset_n = 0 at the edge ending cycle 1 of a write -> Data = Z next cycle; no RspValid; ReqReady = 1 after release.
REQ-039 SHALL check: ReqValid = 1 during RWAIT with ReqWrite = 1 -> no bus drive and state unchanged until IDLE.
REQ-040 SHALL check: parameters HOLD = 3, TURN = 2 -> BusOE high for exactly 3 cycles and Z for exactly 2 cycles before ReqReady = 1.
